// File: rtl/multicycle_datapath_if.sv
// Memory-side bus of the multicycle datapath: instruction fetch (req/valid) and data access (req/ready).
// The core drives the master modport; memory models drive the slave modport.
interface multicycle_datapath_if #(
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_valid;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_valid, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_valid, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-ISA datapath with DATA_W-wide registers, internal control FSM and stallable memories.
// Optional OVERFLOW_TRAP_EN: signed overflow on ADD/SUB/ADDI halts the core instead of retiring.
module multicycle_datapath #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int                PC_STEP  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  multicycle_datapath_if.master   mem,
  output logic [DATA_W-1:0]       pc_out_o,
  output logic                    instr_done_o,
  output logic                    halted_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        pc_q, pc_d;
  logic [15:0]              ir_q, ir_d;
  logic [DATA_W-1:0]        a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]        alu_q, alu_d, mdr_q, mdr_d;
  logic [3:0][DATA_W-1:0]   rf_q, rf_d;
  logic                     imem_req_q, imem_req_d;
  logic                     dmem_req_q, dmem_req_d;
  logic                     dmem_we_q, dmem_we_d;
  logic                     retire;

  logic [3:0]        op;
  logic [1:0]        rs, rt, rd, funct, wr_idx;
  logic [3:0]        shamt;
  logic [DATA_W-1:0] imm_sext;

  assign op       = ir_q[15:12];
  assign rs       = ir_q[11:10];
  assign rt       = ir_q[9:8];
  assign rd       = ir_q[7:6];
  assign shamt    = ir_q[5:2];
  assign funct    = ir_q[1:0];
  assign imm_sext = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign wr_idx   = (op == OP_R) ? rd : rt;

  logic [DATA_W-1:0] op2, sum, diff, alu_res, pc_seq, pc_br;
  logic              taken;

  always_comb begin
    op2     = (op == OP_R) ? b_q : imm_sext;
    sum     = a_q + op2;
    diff    = a_q - b_q;
    alu_res = sum;
    if (op == OP_R) begin
      case (funct)
        2'b00:   alu_res = sum;
        2'b01:   alu_res = diff;
        2'b10:   alu_res = a_q & b_q;
        default: alu_res = b_q << shamt;
      endcase
    end
  end

  assign taken  = (op == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
  assign pc_seq = pc_q + STEP;
  assign pc_br  = pc_seq + (imm_sext << 1);

`ifdef OVERFLOW_TRAP_EN
  logic ovf;
  // Signed overflow: operands agree in sign but the result does not (add), or differ and result flips (sub).
  always_comb begin
    ovf = 1'b0;
    if (op == OP_ADDI || (op == OP_R && funct == 2'b00))
      ovf = (a_q[DATA_W-1] == op2[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
    else if (op == OP_R && funct == 2'b01)
      ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
  end
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    rf_d      = rf_q;
    dmem_we_d = dmem_we_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && mem.imem_valid) begin
          ir_d    = mem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        case (op)
          OP_R, OP_ADDI: begin
`ifdef OVERFLOW_TRAP_EN
            state_d = ovf ? S_HALT : S_WB;
`else
            state_d = S_WB;
`endif
          end
          OP_LW: begin
            dmem_we_d = 1'b0;
            state_d   = S_MEM;
          end
          OP_SW: begin
            dmem_we_d = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            retire  = 1'b1;
            pc_d    = taken ? pc_br : pc_seq;
            state_d = S_FETCH;
          end
          default: begin
            retire  = 1'b1;
            pc_d    = pc_seq;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && mem.dmem_ready) begin
          dmem_we_d = 1'b0;
          if (dmem_we_q) begin
            retire  = 1'b1;
            pc_d    = pc_seq;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem.dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_d[wr_idx] = (op == OP_LW) ? mdr_q : alu_q;
        retire       = 1'b1;
        pc_d         = pc_seq;
        state_d      = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Requests are registered copies of "next state is the access state".
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      pc_q       <= PC_RESET;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      rf_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      rf_q       <= rf_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
    end
  end

  assign mem.imem_req   = imem_req_q;
  assign mem.imem_addr  = pc_q;
  assign mem.dmem_req   = dmem_req_q;
  assign mem.dmem_we    = dmem_we_q;
  assign mem.dmem_addr  = alu_q;
  assign mem.dmem_wdata = b_q;
  assign pc_out_o       = pc_q;
  assign instr_done_o   = retire & ~rst_i;
  assign halted_o       = (state_q == S_HALT);

endmodule
